alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command sequencer in front of the ALU in the tt_um_ALU_Completa top level.
//  - Accepts a byte stream of commands (header, operand A, operand B) over valid/ready.
//  - Drives the ALU operand/opcode lines and waits the ALU latency.
//  - Captures result and flags, then returns them over a valid/ready result port.
//  - Keeps the last result as an accumulator so ops can be chained without resending A.
// PARAMETERS
//  ALU_LAT  1  cycles from alu_start to alu_result/alu_flags valid (1..15)
//  ACC_RST  0  accumulator value after reset (8 bits)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  ena         in   1  design enable; low = full stall, all state held
//  cmd_data    in   8  command byte (header or operand)
//  cmd_valid   in   1  cmd_data valid
//  cmd_ready   out  1  byte accepted when cmd_valid & cmd_ready at clk edge
//  alu_op      out  4  opcode to ALU
//  alu_a       out  8  operand A to ALU
//  alu_b       out  8  operand B to ALU
//  alu_start   out  1  one-cycle pulse: ALU inputs valid
//  alu_result  in   8  ALU result
//  alu_flags   in   4  ALU flags {C,Z,N,V}
//  res_data    out  8  captured result
//  res_flags   out  4  captured flags
//  res_valid   out  1  result available
//  res_ready   in   1  result consumed when res_valid & res_ready
//  busy        out  1  high in any state other than IDLE
//  err         out  1  sticky: illegal header seen; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, accumulator = ACC_RST.
//  - Header byte: [3:0] op, [4] ACC (A = accumulator, no A byte), [5] UNARY (B = 0, no B byte).
//    [7:6] must be 00.
//  - IDLE: cmd_ready=1. On header accept, latch op/flags and go to GET_A.
//    If ACC, skip GET_A (alu_a = acc). If UNARY, skip GET_B. Route to EXEC when both are skipped.
//  - Illegal header ([7:6]!=00): set err, drop the byte, stay in IDLE.
//  - GET_A / GET_B: cmd_ready=1. An accepted byte loads alu_a / alu_b and advances the state.
//  - EXEC: cmd_ready=0, alu_start=1 for exactly this cycle. Go to WAIT; load the wait counter with ALU_LAT.
//  - WAIT: decrement each cycle. At zero, register alu_result/alu_flags into res_data/res_flags
//    and the accumulator, set res_valid, go to HOLD.
//  - Latency: header-to-res_valid = bytes_sent + 1 + ALU_LAT cycles.
//  - HOLD: res_valid=1 and res_data stable until res_ready.
//    Handshake cycle: clear res_valid, go to IDLE. cmd_ready stays 0 in HOLD (no overlap).
//  - alu_op/alu_a/alu_b stay stable from EXEC until the next command's bytes load them.
//  - ena=0 in any state: no transitions, cmd_ready=0, alu_start=0.
//    A pending alu_start is deferred until ena returns.
//    The WAIT counter freezes; res_valid holds.
//  - rst_n low mid-command: immediate return to reset values; partial command discarded.
//  - Accumulator updates only at result capture; err does not block further commands.
// TESTING
//  1. Hdr 0x02, A=0x05, B=0x03, ALU_LAT=1, stub returns A+B
//     -> alu_start one pulse with a=05 b=03 op=2; res_data=0x08; res_valid 5 cycles after hdr accept.
//  2. Follow with hdr 0x12 (ACC), B=0x10
//     -> alu_a=0x08 with no A byte consumed; res_data=0x18; acc=0x18.
//  3. Hdr 0x21 (UNARY), A=0xF0, with res_ready held low 10 cycles
//     -> alu_b=0; res_valid and res_data stay stable 10 cycles; cmd_ready=0 throughout HOLD.
//  4. Hdr 0xC0
//     -> err=1, state IDLE, busy=0; a following valid command still completes with err still 1.
//  5. Drop ena for 3 cycles during WAIT (ALU_LAT=4), then assert rst_n=0 mid GET_B
//     -> result delayed exactly 3 cycles; after reset all outputs 0 and acc=ACC_RST.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Purpose : bundle of the command, ALU and result signals around alu_op_sequencer.
// Latency : none, wiring only.
// Backpr. : cmd_valid/cmd_ready on the command side, res_valid/res_ready on the result side.
// Ports   : cmd_data/cmd_valid/cmd_ready - command byte stream in
//           alu_op/alu_a/alu_b/alu_start  - operands and strobe out to the ALU
//           alu_result/alu_flags          - ALU answer {C,Z,N,V}
//           res_data/res_flags/res_valid/res_ready - captured result out
//           busy/err                      - status
// slave  : the sequencer side.
// master : the side that sends commands, models the ALU and takes results.
interface alu_op_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_start;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic       err;

  modport slave (
    input  cmd_data, cmd_valid, alu_result, alu_flags, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, alu_start,
           res_data, res_flags, res_valid, busy, err
  );

  modport master (
    output cmd_data, cmd_valid, alu_result, alu_flags, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, alu_start,
           res_data, res_flags, res_valid, busy, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Purpose : byte-stream command sequencer feeding an ALU, with result accumulator.
// Latency : header accept to res_valid = bytes_sent + 1 + ALU_LAT cycles (back-to-back bytes).
// Backpr. : cmd_ready low outside IDLE/GET_A/GET_B; result held in HOLD until res_ready.
// Ports   : i_clk, i_rst_n (async active-low), i_ena (low = full stall, state held),
//           io_bus (slave modport of alu_op_sequencer_if).
// Header  : [3:0] op, [4] ACC (A from accumulator), [5] UNARY (B = 0), [7:6] must be 00.
module alu_op_sequencer #(
  parameter int unsigned ALU_LAT = 1,
  parameter logic [7:0]  ACC_RST = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  alu_op_sequencer_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_EXEC  = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_acc;
  logic [7:0] r_res;
  logic [3:0] r_flags;
  logic [3:0] r_cnt;
  logic       r_unary;
  logic       r_err;
  logic       w_cmd_ready;
  logic       w_alu_start;
  logic       w_fire;
  logic       w_hdr_ok;

  // w_cmd_ready already carries i_ena, so a byte is never taken during a stall.
  assign w_fire   = io_bus.cmd_valid & w_cmd_ready;
  assign w_hdr_ok = (io_bus.cmd_data[7:6] == 2'b00);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; nothing moves while i_ena is low.
  always_comb begin
    w_next = r_state;
    if (i_ena) begin
      case (r_state)
        S_IDLE: begin
          // Illegal headers are dropped here and leave the state in IDLE.
          if (w_fire && w_hdr_ok) begin
            if (!io_bus.cmd_data[4])      w_next = S_GET_A;
            else if (!io_bus.cmd_data[5]) w_next = S_GET_B;
            else                          w_next = S_EXEC;
          end
        end
        S_GET_A: if (w_fire) w_next = r_unary ? S_EXEC : S_GET_B;
        S_GET_B: if (w_fire) w_next = S_EXEC;
        S_EXEC:  w_next = S_WAIT;
        S_WAIT:  if (r_cnt == 4'd0) w_next = S_HOLD;
        S_HOLD:  if (io_bus.res_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Output decode. alu_start sits on the EXEC state, so a stall in EXEC
  // simply postpones the pulse until i_ena returns.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_alu_start = 1'b0;
    if (i_ena) begin
      case (r_state)
        S_IDLE, S_GET_A, S_GET_B: w_cmd_ready = 1'b1;
        S_EXEC:                   w_alu_start = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand, counter, result and accumulator registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= 4'h0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_acc   <= ACC_RST;
      r_res   <= 8'h00;
      r_flags <= 4'h0;
      r_cnt   <= 4'h0;
      r_unary <= 1'b0;
      r_err   <= 1'b0;
    end else if (i_ena) begin
      if (w_fire) begin
        case (r_state)
          S_IDLE: begin
            if (w_hdr_ok) begin
              r_op    <= io_bus.cmd_data[3:0];
              r_unary <= io_bus.cmd_data[5];
              if (io_bus.cmd_data[4]) r_a <= r_acc;
              if (io_bus.cmd_data[5]) r_b <= 8'h00;
            end else begin
              r_err <= 1'b1;
            end
          end
          S_GET_A: r_a <= io_bus.cmd_data;
          S_GET_B: r_b <= io_bus.cmd_data;
          default: ;
        endcase
      end
      // Counter runs ALU_LAT down to zero; the capture happens on the
      // cycle it reads zero, one cycle after the ALU answer is settled.
      if (r_state == S_EXEC) begin
        r_cnt <= LAT_INIT;
      end else if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_res   <= io_bus.alu_result;
          r_flags <= io_bus.alu_flags;
          r_acc   <= io_bus.alu_result;
        end
      end
    end
  end

  assign io_bus.cmd_ready = w_cmd_ready;
  assign io_bus.alu_start = w_alu_start;
  assign io_bus.alu_op    = r_op;
  assign io_bus.alu_a     = r_a;
  assign io_bus.alu_b     = r_b;
  assign io_bus.res_data  = r_res;
  assign io_bus.res_flags = r_flags;
  assign io_bus.res_valid = (r_state == S_HOLD);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.err       = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : self-checking bench for alu_op_sequencer (two instances, ALU_LAT 1 and 4).
// Latency : checks header/last-byte to res_valid timing against bytes_sent + 1 + ALU_LAT.
// Backpr. : exercises res_ready hold-off, ena stalls and reset mid-command.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ena;
  logic       sel;
  logic       cmd_valid;
  logic       res_ready;
  logic [7:0] cmd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer_if bus1 ();
  alu_op_sequencer_if bus4 ();

  // ALU stand-in: adder with {C,Z,N,V}; operands are held steady by the DUT.
  function automatic logic [11:0] alu_stub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {s[8], (s[7:0] == 8'h00), s[7], ((a[7] == b[7]) && (s[7] != a[7])), s[7:0]};
  endfunction

  assign bus1.cmd_data  = cmd_data;
  assign bus1.cmd_valid = cmd_valid & ~sel;
  assign bus1.res_ready = res_ready & ~sel;
  assign {bus1.alu_flags, bus1.alu_result} = alu_stub(bus1.alu_a, bus1.alu_b);
  assign bus4.cmd_data  = cmd_data;
  assign bus4.cmd_valid = cmd_valid & sel;
  assign bus4.res_ready = res_ready & sel;
  assign {bus4.alu_flags, bus4.alu_result} = alu_stub(bus4.alu_a, bus4.alu_b);

  alu_op_sequencer #(.ALU_LAT(1), .ACC_RST(8'h5A)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .io_bus(bus1));
  alu_op_sequencer #(.ALU_LAT(4), .ACC_RST(8'h5A)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .io_bus(bus4));

  logic       w_cmd_ready, w_alu_start, w_res_valid, w_busy, w_err;
  logic [3:0] w_alu_op, w_res_flags;
  logic [7:0] w_alu_a, w_alu_b, w_res_data;
  assign w_cmd_ready = sel ? bus4.cmd_ready : bus1.cmd_ready;
  assign w_alu_start = sel ? bus4.alu_start : bus1.alu_start;
  assign w_res_valid = sel ? bus4.res_valid : bus1.res_valid;
  assign w_busy      = sel ? bus4.busy      : bus1.busy;
  assign w_err       = sel ? bus4.err       : bus1.err;
  assign w_alu_op    = sel ? bus4.alu_op    : bus1.alu_op;
  assign w_res_flags = sel ? bus4.res_flags : bus1.res_flags;
  assign w_alu_a     = sel ? bus4.alu_a     : bus1.alu_a;
  assign w_alu_b     = sel ? bus4.alu_b     : bus1.alu_b;
  assign w_res_data  = sel ? bus4.res_data  : bus1.res_data;

  // Records every alu_start pulse of the selected instance.
  int         start_cnt = 0;
  logic [7:0] st_a, st_b;
  logic [3:0] st_op;
  always @(negedge clk) begin
    if (w_alu_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      st_a      <= w_alu_a;
      st_b      <= w_alu_b;
      st_op     <= w_alu_op;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one byte from a negedge; returns the cycle count seen at the
  // negedge right after the accepting edge.
  task automatic send(input logic [7:0] d, output int acc_cyc);
    int n;
    n = 0;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (w_cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", w_cmd_ready, 1'b1);
    @(negedge clk);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int rc);
    int n;
    n = 0;
    while (w_res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", w_res_valid, 1'b1);
    rc = cyc;
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_rv_clr"}, w_res_valid, 1'b0);
    check({tag, "_idle"}, w_busy, 1'b0);
  endtask

  task automatic run_cmd(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b,
                         input int gap, output int lat_hdr, output int lat_last);
    int c0, cl, cr;
    send(hdr, c0);
    cl = c0;
    if (!hdr[4]) begin idle($urandom_range(0, gap)); send(a, cl); end
    if (!hdr[5]) begin idle($urandom_range(0, gap)); send(b, cl); end
    wait_res(cr);
    lat_hdr  = cr - c0;
    lat_last = cr - cl;
  endtask

  task automatic check_reset_outputs(input string tag, input bit with_ready);
    check({tag, "_busy"}, w_busy, 1'b0);
    check({tag, "_err"}, w_err, 1'b0);
    check({tag, "_rv"}, w_res_valid, 1'b0);
    check({tag, "_rdata"}, w_res_data, 8'h00);
    check({tag, "_rflags"}, w_res_flags, 4'h0);
    check({tag, "_op"}, w_alu_op, 4'h0);
    check({tag, "_a"}, w_alu_a, 8'h00);
    check({tag, "_b"}, w_alu_b, 8'h00);
    check({tag, "_start"}, w_alu_start, 1'b0);
    if (with_ready) check({tag, "_cmd_rdy"}, w_cmd_ready, 1'b0);
  endtask

  // Reference ALU answer computed from integer arithmetic.
  function automatic logic [3:0] ref_flags(input int a, input int b);
    int u, s;
    logic c, z, n, v;
    u = a + b;
    s = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b);
    c = (u > 255);
    z = ((u % 256) == 0);
    n = ((u % 256) >= 128);
    v = (s > 127) || (s < -128);
    return {c, z, n, v};
  endfunction

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] er;
    logic [3:0] ef;
    int         lat;
    int         hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, ca, cb, cr, lh, ll, s0, bad, lat;
    logic [7:0] hdr, a, b, ea, eb, macc;
    logic       merr;

    // On the ALU_LAT=1 instance, starting from acc = 0x5A.
    tbl[0] = '{8'h02, 8'h05, 8'h03, 8'h05, 8'h03, 8'h08, 4'h0, 5, 0};
    tbl[1] = '{8'h12, 8'h00, 8'h10, 8'h08, 8'h10, 8'h18, 4'h0, 4, 0};
    tbl[2] = '{8'h21, 8'hF0, 8'h00, 8'hF0, 8'h00, 8'hF0, 4'h2, 4, 10};
    tbl[3] = '{8'h3F, 8'h00, 8'h00, 8'hF0, 8'h00, 8'hF0, 4'h2, 3, 0};
    tbl[4] = '{8'h1A, 8'h00, 8'h20, 8'hF0, 8'h20, 8'h10, 4'h8, 4, 0};
    tbl[5] = '{8'h0F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 4'hD, 5, 0};

    rst_n = 1'b0; ena = 1'b0; sel = 1'b0;
    cmd_valid = 1'b0; cmd_data = 8'h00; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; check_reset_outputs("rst1", 1'b1);
    sel = 1'b1; check_reset_outputs("rst4", 1'b1);
    sel = 1'b0;
    rst_n = 1'b1; ena = 1'b1;
    @(negedge clk);
    check("idle_ready", w_cmd_ready, 1'b1);

    // Table-driven commands on the ALU_LAT=1 instance.
    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      run_cmd(tbl[i].hdr, tbl[i].a, tbl[i].b, 0, lh, ll);
      check($sformatf("vec%0d_lat", i), lh, tbl[i].lat);
      check($sformatf("vec%0d_starts", i), start_cnt - s0, 1);
      check($sformatf("vec%0d_op", i), st_op, tbl[i].hdr[3:0]);
      check($sformatf("vec%0d_a", i), st_a, tbl[i].ea);
      check($sformatf("vec%0d_b", i), st_b, tbl[i].eb);
      check($sformatf("vec%0d_res", i), w_res_data, tbl[i].er);
      check($sformatf("vec%0d_flags", i), w_res_flags, tbl[i].ef);
      check($sformatf("vec%0d_busy", i), w_busy, 1'b1);
      if (tbl[i].hold > 0) begin
        bad = 0;
        for (int h = 0; h < tbl[i].hold; h++) begin
          if (!(w_res_valid === 1'b1 && w_res_data === tbl[i].er && w_cmd_ready === 1'b0))
            bad++;
          @(negedge clk);
        end
        check($sformatf("vec%0d_hold_stable", i), bad, 0);
      end
      consume($sformatf("vec%0d", i));
    end

    // Illegal header: flagged, dropped, and the next command still runs.
    send(8'hC0, c0);
    check("ill_err", w_err, 1'b1);
    check("ill_busy", w_busy, 1'b0);
    check("ill_ready", w_cmd_ready, 1'b1);
    run_cmd(8'h04, 8'h01, 8'h02, 0, lh, ll);
    check("post_ill_res", w_res_data, 8'h03);
    check("post_ill_err", w_err, 1'b1);
    consume("post_ill");

    // ALU_LAT=4 instance: stall while in EXEC defers the alu_start pulse.
    sel = 1'b1;
    send(8'h02, c0);
    send(8'h01, ca);
    cmd_data = 8'h01; cmd_valid = 1'b1;
    check("defer_rdy", w_cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; ena = 1'b0;
    cb = cyc; s0 = start_cnt;
    @(negedge clk);
    check("defer_start_lo1", w_alu_start, 1'b0);
    check("defer_cmd_rdy", w_cmd_ready, 1'b0);
    check("defer_busy", w_busy, 1'b1);
    @(negedge clk);
    check("defer_start_lo2", w_alu_start, 1'b0);
    @(posedge clk);
    #1 ena = 1'b1;
    wait_res(cr);
    check("defer_lat", cr - cb, 8);
    check("defer_starts", start_cnt - s0, 1);
    check("defer_res", w_res_data, 8'h02);
    consume("defer");

    // Stall for 3 cycles in WAIT: result moves out by exactly 3 cycles.
    send(8'h02, c0);
    send(8'h11, ca);
    send(8'h22, cb);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    wait_res(cr);
    check("wait_stall_lat", cr - c0, 3 + 1 + 4 + 3);
    check("wait_stall_res", w_res_data, 8'h33);
    consume("wait_stall");

    // Reset in the middle of GET_B.
    send(8'h02, c0);
    send(8'h33, ca);
    check("pre_rst_busy", w_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    sel = 1'b1; check_reset_outputs("mid_rst4", 1'b0);
    sel = 1'b0; check_reset_outputs("mid_rst1", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      run_cmd(8'h30, 8'h00, 8'h00, 0, lh, ll);
      check($sformatf("acc_rst%0d_a", s), st_a, 8'h5A);
      check($sformatf("acc_rst%0d_res", s), w_res_data, 8'h5A);
      consume($sformatf("acc_rst%0d", s));
    end

    // Randomised commands against the reference model on both instances.
    for (int s = 0; s < 2; s++) begin
      sel  = (s == 1);
      lat  = (s == 1) ? 4 : 1;
      macc = 8'h5A;
      merr = 1'b0;
      for (int k = 0; k < 30; k++) begin
        hdr = 8'($urandom);
        a   = 8'($urandom);
        b   = 8'($urandom);
        if ($urandom_range(0, 7) != 0) hdr[7:6] = 2'b00;
        else if (hdr[7:6] == 2'b00) hdr[7] = 1'b1;
        if (hdr[7:6] != 2'b00) begin
          send(hdr, c0);
          merr = 1'b1;
          check("rnd_ill_err", w_err, 1'b1);
          check("rnd_ill_busy", w_busy, 1'b0);
          continue;
        end
        ea = hdr[4] ? macc : a;
        eb = hdr[5] ? 8'h00 : b;
        s0 = start_cnt;
        run_cmd(hdr, a, b, 3, lh, ll);
        check("rnd_lat", ll, 2 + lat);
        check("rnd_starts", start_cnt - s0, 1);
        check("rnd_op", st_op, hdr[3:0]);
        check("rnd_a", st_a, ea);
        check("rnd_b", st_b, eb);
        check("rnd_res", w_res_data, (int'(ea) + int'(eb)) % 256);
        check("rnd_flags", w_res_flags, ref_flags(int'(ea), int'(eb)));
        check("rnd_err", w_err, merr);
        idle($urandom_range(0, 3));
        check("rnd_rv_held", w_res_valid, 1'b1);
        consume("rnd");
        macc = 8'((int'(ea) + int'(eb)) % 256);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
